// File: rtl/sipo_deframer_pkg.sv
// sipo_pkg: shared FSM state type, default width and counter-width helper for the deframer.
package sipo_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_deframer_if.sv
// sipo_deframer_if: serial input stream and valid/ready parallel output of the deframer.
interface sipo_deframer_if #(
    parameter int WIDTH = 4
);

    logic             s_in;
    logic             s_valid;
    logic             sync;
    logic [WIDTH-1:0] p_out;
    logic             p_valid;
    logic             p_ready;
    logic             overrun;
    logic             parity_err;

    modport master (
        output s_in, s_valid, sync, p_ready,
        input  p_out, p_valid, overrun, parity_err
    );

    modport slave (
        input  s_in, s_valid, sync, p_ready,
        output p_out, p_valid, overrun, parity_err
    );

endinterface

// File: rtl/sipo_deframer_out_reg.sv
// sipo_out_reg: valid/ready holding register; a load while full and not consumed is dropped
// and raises the sticky overrun flag.
module sipo_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_flag,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_flag,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_flag;
    logic             r_overrun;
    logic             w_accept;
    logic             w_drop;

    // Consumption in the same cycle frees the slot for the incoming word.
    assign w_accept = i_load && (!r_valid || i_ready);
    assign w_drop   = i_load && r_valid && !i_ready;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_flag    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data  <= i_data;
                r_flag  <= i_flag;
                r_valid <= 1'b1;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
            if (w_drop) r_overrun <= 1'b1;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_flag    = r_flag;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_deframer.sv
// sipo_deframer: collects an LSB-first sync-marked serial stream into WIDTH-bit words.
// Define SIPO_PARITY_CHECK_EN to expect a trailing even-parity bit per frame.
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             clear,
    sipo_deframer_if.slave   io_bus
);

    localparam int CNT_W = cnt_w(WIDTH);
`ifdef SIPO_PARITY_CHECK_EN
    localparam state_t AFTER_LAST = PARITY;
`else
    localparam state_t AFTER_LAST = IDLE;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shnext;
    logic [CNT_W-1:0] r_cnt;
    logic             w_start;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_data;
    logic             w_flag;

    // A sync bit always starts a fresh word, abandoning any partial one.
    assign w_start  = io_bus.s_valid && io_bus.sync;
    assign w_last   = (r_state == SHIFT) && io_bus.s_valid && !io_bus.sync &&
                      (r_cnt == CNT_W'(WIDTH - 1));
    assign w_shnext = {io_bus.s_in, r_shreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (clear) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = w_start            ? SHIFT      :
                 !io_bus.s_valid    ? r_state    :
                 w_last             ? AFTER_LAST :
                 r_state == PARITY  ? IDLE       : r_state;
    end

    always_comb begin
`ifdef SIPO_PARITY_CHECK_EN
        w_load = (r_state == PARITY) && io_bus.s_valid && !io_bus.sync;
        w_data = r_shreg;
        w_flag = ^r_shreg ^ io_bus.s_in;
`else
        w_load = w_last;
        w_data = w_shnext;
        w_flag = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_start) begin
            r_shreg <= w_shnext;
            r_cnt   <= CNT_W'(1);
        end else if ((r_state == SHIFT) && io_bus.s_valid) begin
            r_shreg <= w_shnext;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    sipo_out_reg #(.WIDTH(WIDTH)) u_out_reg (
        .clk       (clk),
        .clear     (clear),
        .i_load    (w_load),
        .i_data    (w_data),
        .i_flag    (w_flag),
        .i_ready   (io_bus.p_ready),
        .o_data    (io_bus.p_out),
        .o_valid   (io_bus.p_valid),
        .o_flag    (io_bus.parity_err),
        .o_overrun (io_bus.overrun)
    );

endmodule
